// File: rtl/dm_cache_ctrl.sv
// dm_cache_ctrl: direct-mapped, multi-word-block cache controller sitting
// between one requester and a slower word-wide memory. Reads that miss refill
// the whole block with a burst; writes go straight through to memory and only
// update the cached copy when the line already holds the block (no allocate).
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata    request, held stable until cpu_ready
//   cpu_rdata, cpu_ready     read data and one-cycle completion pulse
//   mem_req/we/addr/wdata    memory request (block refill or word write)
//   mem_rvalid, mem_rdata    refill words, offset order
//   mem_ready                write acknowledge
//   hit_count, miss_count    saturating lookup counters
module dm_cache_ctrl #(
   parameter int unsigned ADDR_W   = 15,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned INDEX_W  = 10,
   parameter int unsigned OFFSET_W = 2,
   parameter int unsigned CNT_W    = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ready,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic [CNT_W-1:0]  hit_count,
   output logic [CNT_W-1:0]  miss_count
);
   localparam int unsigned TAG_W = ADDR_W - INDEX_W - OFFSET_W;
   localparam int unsigned LINES = 2 ** INDEX_W;
   localparam int unsigned WORDS = 2 ** (INDEX_W + OFFSET_W);

   typedef enum logic [2:0] {IDLE, LOOKUP, REFILL, RESP, WRITE} state_t;
   state_t state, state_nx;

   logic [ADDR_W-1:0]   req_addr;
   logic                req_we;
   logic [DATA_W-1:0]   req_wdata;
   logic                req_hit;
   logic [OFFSET_W-1:0] word_cnt;
   logic [LINES-1:0]    valid;
   logic [TAG_W-1:0]    tag_mem  [LINES];
   logic [DATA_W-1:0]   data_mem [WORDS];

   logic [TAG_W-1:0]    req_tag;
   logic [INDEX_W-1:0]  req_index;
   logic [OFFSET_W-1:0] req_off;
   logic                lookup_hit;
   logic                last_word;
   logic                refill_we;
   logic                write_hit_we;

   assign req_tag      = req_addr[ADDR_W-1 -: TAG_W];
   assign req_index    = req_addr[OFFSET_W +: INDEX_W];
   assign req_off      = req_addr[OFFSET_W-1:0];
   assign lookup_hit   = valid[req_index] && (tag_mem[req_index] == req_tag);
   assign last_word    = (word_cnt == '1);
   assign refill_we    = (state == REFILL) && mem_rvalid;
   // The hit flag is latched in LOOKUP; the arrays cannot change before the
   // write is acknowledged, so it still describes the line in WRITE.
   assign write_hit_we = (state == WRITE) && mem_ready && req_hit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      cpu_ready = 1'b0;
      cpu_rdata = '0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state)
         IDLE: begin
            if (cpu_req) state_nx = LOOKUP;
         end
         LOOKUP: begin
            if (req_we) begin
               state_nx = WRITE;
            end else if (lookup_hit) begin
               cpu_ready = 1'b1;
               cpu_rdata = data_mem[{req_index, req_off}];
               state_nx  = IDLE;
            end else begin
               state_nx = REFILL;
            end
         end
         REFILL: begin
            mem_req  = 1'b1;
            mem_addr = {req_tag, req_index, {OFFSET_W{1'b0}}};
            if (mem_rvalid && last_word) state_nx = RESP;
         end
         RESP: begin
            cpu_ready = 1'b1;
            cpu_rdata = data_mem[{req_index, req_off}];
            state_nx  = IDLE;
         end
         WRITE: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = req_addr;
            mem_wdata = req_wdata;
            if (mem_ready) begin
               cpu_ready = 1'b1;
               state_nx  = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_addr   <= '0;
         req_we     <= 1'b0;
         req_wdata  <= '0;
         req_hit    <= 1'b0;
         word_cnt   <= '0;
         valid      <= '0;
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if ((state == IDLE) && cpu_req) begin
            req_addr  <= cpu_addr;
            req_we    <= cpu_we;
            req_wdata <= cpu_wdata;
         end
         if (state == LOOKUP) begin
            req_hit <= lookup_hit;
            if (lookup_hit) begin
               if (hit_count != '1) hit_count <= hit_count + CNT_W'(1);
            end else begin
               if (miss_count != '1) miss_count <= miss_count + CNT_W'(1);
            end
            // Invalidate up front so an abandoned refill never leaves a
            // partially filled line marked valid.
            if (!req_we && !lookup_hit) begin
               valid[req_index] <= 1'b0;
               word_cnt         <= '0;
            end
         end
         if (refill_we) begin
            word_cnt <= word_cnt + OFFSET_W'(1);
            if (last_word) valid[req_index] <= 1'b1;
         end
      end
   end

   // Data and tag storage carry no reset; only the valid bits qualify them.
   always_ff @(posedge clk) begin
      if (refill_we) begin
         data_mem[{req_index, word_cnt}] <= mem_rdata;
         if (last_word) tag_mem[req_index] <= req_tag;
      end
      if (write_hit_we) data_mem[{req_index, req_off}] <= req_wdata;
   end

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// tb_dm_cache_ctrl: directed bench for dm_cache_ctrl. A reference memory holds
// the architectural contents (reads must always return it), and a line table of
// valid/tag pairs predicts hit or miss, from which latency and counters follow.
module tb_dm_cache_ctrl;
   logic        clk;
   logic        rst;
   logic        cpu_req;
   logic        cpu_we;
   logic [14:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        cpu_ready;
   logic        mem_req;
   logic        mem_we;
   logic [14:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic [31:0] hit_count;
   logic [31:0] miss_count;

   dm_cache_ctrl #(
      .ADDR_W(15), .DATA_W(32), .INDEX_W(10), .OFFSET_W(2), .CNT_W(32)
   ) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .mem_ready(mem_ready), .hit_count(hit_count), .miss_count(miss_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned ncmp = 0;
   int unsigned nfail = 0;

   logic [31:0] mem [32768];
   bit          mv  [1024];
   logic [2:0]  mt  [1024];
   int unsigned exp_hit = 0;
   int unsigned exp_miss = 0;
   bit          cnt_chk = 0;
   logic [14:0] last_rf_addr;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      ncmp++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
      end
   endtask

   task automatic timeout(input string nm);
      ncmp++;
      nfail++;
      $display("FAIL %s: no cpu_ready within cycle budget (t=%0t)", nm, $time);
   endtask

   // Between transactions: counters match the model and the controller is quiet.
   always @(negedge clk) begin
      if (cnt_chk && !rst) begin
         chk("hit_count", hit_count, exp_hit);
         chk("miss_count", miss_count, exp_miss);
         chk("idle_cpu_ready", cpu_ready, 0);
         chk("idle_mem_req", mem_req, 0);
      end
   end

   task automatic model_reset();
      for (int i = 0; i < 1024; i++) mv[i] = 0;
      exp_hit = 0;
      exp_miss = 0;
   endtask

   // Read; refill words are offered on every gap-th refill cycle.
   task automatic do_read(input logic [14:0] a, input int unsigned gap,
                          output logic [31:0] rd);
      logic [9:0]  idx;
      logic [2:0]  tg;
      logic [14:0] blk;
      bit          hit;
      bit          done;
      int unsigned cyc, k, g;
      idx = a[11:2];
      tg  = a[14:12];
      blk = {a[14:2], 2'b00};
      hit = mv[idx] && (mt[idx] == tg);
      rd  = '0;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a; cpu_wdata = '0;
      @(posedge clk); #1;
      cnt_chk = 0;
      cyc = 0; k = 0; g = 0; done = 0;
      while (!done && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (cpu_ready) begin
            chk("rd_latency", cyc, hit ? 1 : 4 * gap + 2);
            chk("rd_data", cpu_rdata, mem[a]);
            chk("rd_refill_words", k, hit ? 0 : 4);
            rd = cpu_rdata;
            done = 1;
         end else if (mem_req) begin
            chk("rf_mem_we", mem_we, 0);
            chk("rf_mem_addr", mem_addr, blk);
            last_rf_addr = mem_addr;
            g++;
            if (g == gap && k < 4) begin
               g = 0;
               mem_rvalid = 1'b1;
               mem_rdata  = mem[32'(blk) + k];
               k++;
            end
         end
         @(posedge clk); #1;
         mem_rvalid = 1'b0;
         mem_rdata  = $urandom;
         if (done) cpu_req = 1'b0;
      end
      if (!done) begin
         timeout("rd_timeout");
         cpu_req = 1'b0;
      end
      if (hit) exp_hit++;
      else begin
         exp_miss++;
         mv[idx] = 1;
         mt[idx] = tg;
      end
      cnt_chk = 1;
   endtask

   // Write-through; mem_ready is given in the dly-th cycle of the memory write.
   task automatic do_write(input logic [14:0] a, input logic [31:0] d,
                           input int unsigned dly);
      logic [9:0]  idx;
      logic [2:0]  tg;
      bit          hit;
      bit          done;
      int unsigned cyc, w;
      idx = a[11:2];
      tg  = a[14:12];
      hit = mv[idx] && (mt[idx] == tg);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
      @(posedge clk); #1;
      cnt_chk = 0;
      cyc = 0; w = 0; done = 0;
      while (!done && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (mem_req && mem_we) begin
            chk("wr_mem_addr", mem_addr, a);
            chk("wr_mem_wdata", mem_wdata, d);
            w++;
            if (w == dly) begin
               mem_ready = 1'b1;
               #1;
               chk("wr_ack_ready", cpu_ready, 1);
               chk("wr_latency", cyc, 1 + dly);
               done = 1;
            end else begin
               chk("wr_wait_ready", cpu_ready, 0);
            end
         end else begin
            chk("wr_no_refill", mem_req, 0);
            chk("wr_wait_ready", cpu_ready, 0);
         end
         @(posedge clk); #1;
         mem_ready = 1'b0;
         if (done) begin cpu_req = 1'b0; cpu_we = 1'b0; end
      end
      if (!done) begin
         timeout("wr_timeout");
         cpu_req = 1'b0; cpu_we = 1'b0;
      end
      mem[a] = d;
      if (hit) exp_hit++;
      else exp_miss++;
      cnt_chk = 1;
   endtask

   // Read miss abandoned by reset just as the 2nd refill word would arrive.
   task automatic read_with_reset(input logic [14:0] a);
      bit          done;
      int unsigned cyc, k;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
      @(posedge clk); #1;
      cnt_chk = 0;
      cyc = 0; k = 0; done = 0;
      while (!done && cyc < 200) begin
         @(negedge clk);
         cyc++;
         chk("rr_no_ready", cpu_ready, 0);
         if (mem_req) begin
            if (k == 1) begin
               rst = 1'b1;
               #1;
               chk("rr_cpu_ready", cpu_ready, 0);
               chk("rr_cpu_rdata", cpu_rdata, 0);
               chk("rr_mem_req", mem_req, 0);
               chk("rr_mem_we", mem_we, 0);
               chk("rr_mem_addr", mem_addr, 0);
               chk("rr_mem_wdata", mem_wdata, 0);
               chk("rr_hit_count", hit_count, 0);
               chk("rr_miss_count", miss_count, 0);
               done = 1;
            end else begin
               mem_rvalid = 1'b1;
               mem_rdata  = mem[32'({a[14:2], 2'b00}) + k];
               k++;
            end
         end
         @(posedge clk); #1;
         mem_rvalid = 1'b0;
      end
      if (!done) timeout("rr_timeout");
      cpu_req = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      cnt_chk = 1;
   endtask

   logic [31:0] rd;

   initial begin
      for (int i = 0; i < 32768; i++) mem[i] = 32'hA0 + i;
      model_reset();
      rst = 1'b1;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      mem_rvalid = 1'b0; mem_rdata = '0; mem_ready = 1'b0;
      last_rf_addr = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_cpu_ready", cpu_ready, 0);
      chk("rst_cpu_rdata", cpu_rdata, 0);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_hit_count", hit_count, 0);
      chk("rst_miss_count", miss_count, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      cnt_chk = 1;

      // Cold miss and refill, then a hit in the same block.
      do_read(15'h0000, 1, rd);
      chk("pin_first_rdata", rd, 32'hA0);
      chk("pin_first_miss", miss_count, 1);
      do_read(15'h0002, 1, rd);
      chk("pin_hit_rdata", rd, 32'hA2);
      chk("pin_first_hit", hit_count, 1);

      // Conflict on index 1: tags 0 and 1 evict each other.
      do_read(15'h0004, 1, rd);
      do_read(15'h1004, 1, rd);
      chk("pin_conflict_rf_addr", last_rf_addr, 15'h1004);
      chk("pin_conflict_rdata", rd, 32'h10A4);
      do_read(15'h0004, 1, rd);
      chk("pin_conflict_miss", miss_count, 4);

      // Write hit updates the line; read it back as a hit.
      do_write(15'h0001, 32'hDEADBEEF, 3);
      do_read(15'h0001, 1, rd);
      chk("pin_wr_hit_rdata", rd, 32'hDEADBEEF);
      chk("pin_wr_hit_count", hit_count, 3);

      // Write miss goes to memory only; the later read still misses.
      do_write(15'h2008, 32'h12345678, 1);
      do_read(15'h2008, 1, rd);
      chk("pin_wr_miss_rdata", rd, 32'h12345678);
      chk("pin_wr_miss_count", miss_count, 6);

      // Spurious memory strobes while idle must be ignored.
      mem_rvalid = 1'b1; mem_ready = 1'b1; mem_rdata = 32'hBAD0BAD0;
      repeat (3) begin
         @(negedge clk);
         chk("spur_mem_req", mem_req, 0);
         chk("spur_cpu_ready", cpu_ready, 0);
         @(posedge clk); #1;
      end
      mem_rvalid = 1'b0; mem_ready = 1'b0;

      // Refill with a word only every third cycle, then hit in that block.
      do_read(15'h0031, 3, rd);
      chk("pin_gap_rdata", rd, 32'hD1);
      do_read(15'h0033, 1, rd);
      chk("pin_gap_hit_rdata", rd, 32'hD3);
      do_read(15'h0000, 1, rd);
      chk("pin_line0_still_valid", rd, 32'hA0);

      // Reset in the middle of a refill; everything is cold afterwards.
      read_with_reset(15'h0040);
      do_read(15'h0040, 1, rd);
      chk("pin_post_rst_rdata", rd, 32'hE0);
      chk("pin_post_rst_miss", miss_count, 1);
      do_read(15'h0000, 1, rd);
      chk("pin_post_rst_line0_miss", miss_count, 2);

      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule
